fifo_stream_monitor: RTL and testbench

// - Parametrised debug monitor on a FIFO's write and read ports; feeds the ILA trigger bus.
// - Detects consecutive duplicate words on each side, overflow attempts and, optionally, read-sequence gaps.
// - Keeps saturating event counters and captures the first error (code + data) until cleared.
// - Generalises the fixed 16/32-bit duplicate checker. Removes the 0xFFFFFFFF seed, so a first word of all-ones is legal.

---
 rtl/fifo_stream_monitor.sv | 232 +++++++++++++++++++++++
 tb/tb_fifo_stream_monitor.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_monitor.sv
// fifo_stream_monitor: debug monitor on a FIFO's write and read ports.
// Latency: an input event in cycle N shows its pulse and counter change in cycle N+2.
// Backpressure: none. The monitor only observes the ports and never stalls the FIFO.
//
// Ports:
//   clk_i, reset_i (sync, active-high), clear_i (same timing as reset)
//   wr_data_i/wr_en_i/full_i          : FIFO write side
//   rd_data_i/rd_en_i/valid_i         : FIFO read side (first-word-fall-through)
//   wr_dup_o/rd_dup_o/seq_err_o       : 1-cycle event pulses
//   trig_o                            : OR of this cycle's events, including overflow
//   wr_cnt_o/rd_cnt_o/err_cnt_o/ovf_cnt_o : saturating counters
//   triggered_o/first_code_o/first_data_o : first-error capture
//
// Optional feature: define MON_SEQ_CHECK_EN to check that each accepted read
// equals the previous accepted read + 1. When it is undefined, seq_err_o is
// tied low and no incrementer is built.
module fifo_stream_monitor #(
  parameter int WR_WIDTH  = 16,
  parameter int RD_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clear_i,
  input  logic [WR_WIDTH-1:0]  wr_data_i,
  input  logic                 wr_en_i,
  input  logic                 full_i,
  input  logic [RD_WIDTH-1:0]  rd_data_i,
  input  logic                 rd_en_i,
  input  logic                 valid_i,
  output logic                 wr_dup_o,
  output logic                 rd_dup_o,
  output logic                 seq_err_o,
  output logic                 trig_o,
  output logic [CNT_WIDTH-1:0] wr_cnt_o,
  output logic [CNT_WIDTH-1:0] rd_cnt_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic [CNT_WIDTH-1:0] ovf_cnt_o,
  output logic                 triggered_o,
  output logic [2:0]           first_code_o,
  output logic [63:0]          first_data_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  localparam logic [2:0] CODE_WR_DUP = 3'd1;
  localparam logic [2:0] CODE_RD_DUP = 3'd2;
  localparam logic [2:0] CODE_OVF    = 3'd3;
  localparam logic [2:0] CODE_SEQ    = 3'd4;

  typedef enum logic {
    ARMED     = 1'b0,
    TRIGGERED = 1'b1
  } state_t;

  // Reset and clear share one path; clear is a subset of reset.
  logic flush;
  assign flush = reset_i | clear_i;

  // ---------------------------------------------------------------------------
  // S1: raw input register
  // ---------------------------------------------------------------------------
  logic [WR_WIDTH-1:0] s1_wr_data;
  logic                s1_wr_en;
  logic                s1_full;
  logic [RD_WIDTH-1:0] s1_rd_data;
  logic                s1_rd_en;
  logic                s1_valid;

  always_ff @(posedge clk_i) begin
    if (flush) begin
      s1_wr_data <= '0;
      s1_wr_en   <= 1'b0;
      s1_full    <= 1'b0;
      s1_rd_data <= '0;
      s1_rd_en   <= 1'b0;
      s1_valid   <= 1'b0;
    end else begin
      s1_wr_data <= wr_data_i;
      s1_wr_en   <= wr_en_i;
      s1_full    <= full_i;
      s1_rd_data <= rd_data_i;
      s1_rd_en   <= rd_en_i;
      s1_valid   <= valid_i;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: event decode against the held last-accepted words
  // ---------------------------------------------------------------------------
  logic [WR_WIDTH-1:0] wr_last;
  logic [RD_WIDTH-1:0] rd_last;
  logic                wr_have_prev;
  logic                rd_have_prev;

  logic wr_acc;
  logic rd_acc;
  logic ovf_ev;
  logic wr_dup_ev;
  logic rd_dup_ev;
  logic seq_ev;
  logic any_ev;

  assign wr_acc    = s1_wr_en & ~s1_full;
  assign rd_acc    = s1_rd_en & s1_valid;
  assign ovf_ev    = s1_wr_en & s1_full;
  assign wr_dup_ev = wr_acc & wr_have_prev & (s1_wr_data == wr_last);
  assign rd_dup_ev = rd_acc & rd_have_prev & (s1_rd_data == rd_last);

`ifdef MON_SEQ_CHECK_EN
  localparam logic [RD_WIDTH-1:0] RD_ONE = RD_WIDTH'(1);
  logic [RD_WIDTH-1:0] rd_expect;
  // Natural wrap of the RD_WIDTH-bit add gives the modulo behaviour.
  assign rd_expect = rd_last + RD_ONE;
  assign seq_ev    = rd_acc & rd_have_prev & (s1_rd_data != rd_expect);
`else
  assign seq_ev    = 1'b0;
`endif

  assign any_ev = wr_dup_ev | rd_dup_ev | ovf_ev | seq_ev;

  // Lowest code wins when several events land in one cycle.
  logic [2:0]  cap_code;
  logic [63:0] cap_data;

  always_comb begin
    cap_code = CODE_SEQ;
    cap_data = 64'(s1_rd_data);
    if (wr_dup_ev) begin
      cap_code = CODE_WR_DUP;
      cap_data = 64'(s1_wr_data);
    end else if (rd_dup_ev) begin
      cap_code = CODE_RD_DUP;
      cap_data = 64'(s1_rd_data);
    end else if (ovf_ev) begin
      cap_code = CODE_OVF;
      cap_data = 64'(s1_wr_data);
    end
  end

  // Held words: every accepted word replaces the held one, duplicates included.
  always_ff @(posedge clk_i) begin
    if (flush) begin
      wr_last      <= '0;
      rd_last      <= '0;
      wr_have_prev <= 1'b0;
      rd_have_prev <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_last      <= s1_wr_data;
        wr_have_prev <= 1'b1;
      end
      if (rd_acc) begin
        rd_last      <= s1_rd_data;
        rd_have_prev <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pulses and saturating counters
  // ---------------------------------------------------------------------------
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic                 en);
    return (en && (v != {CNT_WIDTH{1'b1}})) ? v + CNT_ONE : v;
  endfunction

  always_ff @(posedge clk_i) begin
    if (flush) begin
      wr_dup_o  <= 1'b0;
      rd_dup_o  <= 1'b0;
      seq_err_o <= 1'b0;
      trig_o    <= 1'b0;
      wr_cnt_o  <= '0;
      rd_cnt_o  <= '0;
      err_cnt_o <= '0;
      ovf_cnt_o <= '0;
    end else begin
      wr_dup_o  <= wr_dup_ev;
      rd_dup_o  <= rd_dup_ev;
      seq_err_o <= seq_ev;
      trig_o    <= any_ev;
      wr_cnt_o  <= sat_inc(wr_cnt_o, wr_acc);
      rd_cnt_o  <= sat_inc(rd_cnt_o, rd_acc);
      err_cnt_o <= sat_inc(err_cnt_o, any_ev);
      ovf_cnt_o <= sat_inc(ovf_cnt_o, ovf_ev);
    end
  end

  // ---------------------------------------------------------------------------
  // ARMED / TRIGGERED capture FSM
  // ---------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;
  logic   capture;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ARMED: begin
        if (any_ev) begin
          capture = 1'b1;
          state_d = TRIGGERED;
        end
      end
      TRIGGERED: begin
        state_d = TRIGGERED;
      end
      default: begin
        state_d = ARMED;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      state_q      <= ARMED;
      first_code_o <= 3'd0;
      first_data_o <= 64'd0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        first_code_o <= cap_code;
        first_data_o <= cap_data;
      end
    end
  end

  assign triggered_o = (state_q == TRIGGERED);

endmodule

// File: tb/tb_fifo_stream_monitor.sv
// Testbench for fifo_stream_monitor: directed scenarios plus randomized traffic
// checked against an event-level reference model.
// Counters are built 4 bits wide so that saturation is reached quickly.
module tb_fifo_stream_monitor;

  localparam int WRW = 16;
  localparam int RDW = 32;
  localparam int CW  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic           clear;
  logic [WRW-1:0] wr_data;
  logic           wr_en;
  logic           full;
  logic [RDW-1:0] rd_data;
  logic           rd_en;
  logic           valid;

  logic           wr_dup;
  logic           rd_dup;
  logic           seq_err;
  logic           trig;
  logic [CW-1:0]  wr_cnt;
  logic [CW-1:0]  rd_cnt;
  logic [CW-1:0]  err_cnt;
  logic [CW-1:0]  ovf_cnt;
  logic           triggered;
  logic [2:0]     first_code;
  logic [63:0]    first_data;

  fifo_stream_monitor #(
    .WR_WIDTH (WRW),
    .RD_WIDTH (RDW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .clear_i     (clear),
    .wr_data_i   (wr_data),
    .wr_en_i     (wr_en),
    .full_i      (full),
    .rd_data_i   (rd_data),
    .rd_en_i     (rd_en),
    .valid_i     (valid),
    .wr_dup_o    (wr_dup),
    .rd_dup_o    (rd_dup),
    .seq_err_o   (seq_err),
    .trig_o      (trig),
    .wr_cnt_o    (wr_cnt),
    .rd_cnt_o    (rd_cnt),
    .err_cnt_o   (err_cnt),
    .ovf_cnt_o   (ovf_cnt),
    .triggered_o (triggered),
    .first_code_o(first_code),
    .first_data_o(first_data)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Reference model: processes one cycle's port activity as a transaction,
  // one cycle after it was presented, with the output values it should cause.
  // ---------------------------------------------------------------------------
  logic [WRW-1:0] m_wlast;
  logic           m_whp;
  logic [RDW-1:0] m_rlast;
  logic           m_rhp;
  logic           m_wdup, m_rdup, m_seq, m_trig, m_trigd;
  logic [CW-1:0]  m_wcnt, m_rcnt, m_ecnt, m_ocnt;
  logic [2:0]     m_code;
  logic [63:0]    m_data;
  // transaction waiting to be evaluated
  logic           p_wen, p_full, p_ren, p_valid;
  logic [WRW-1:0] p_wdata;
  logic [RDW-1:0] p_rdata;

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v, input logic en);
    if (!en || v == {CW{1'b1}}) return v;
    return CW'(v + 1);
  endfunction

  task automatic model_reset();
    m_wlast = '0; m_whp = 0; m_rlast = '0; m_rhp = 0;
    m_wdup = 0; m_rdup = 0; m_seq = 0; m_trig = 0; m_trigd = 0;
    m_wcnt = '0; m_rcnt = '0; m_ecnt = '0; m_ocnt = '0;
    m_code = '0; m_data = '0;
    p_wen = 0; p_full = 0; p_ren = 0; p_valid = 0; p_wdata = '0; p_rdata = '0;
  endtask

  task automatic model_apply();
    logic wa, ov, ra, wd, rdd, sq, any;
    logic [RDW-1:0] nxt;
    wa  = p_wen && !p_full;
    ov  = p_wen && p_full;
    ra  = p_ren && p_valid;
    wd  = wa && m_whp && (p_wdata == m_wlast);
    rdd = ra && m_rhp && (p_rdata == m_rlast);
    nxt = m_rlast + 32'd1;
    sq  = 1'b0;
`ifdef MON_SEQ_CHECK_EN
    sq  = ra && m_rhp && (p_rdata != nxt);
`endif
    any = wd || rdd || ov || sq;
    if (!m_trigd && any) begin
      m_trigd = 1'b1;
      if (wd)       begin m_code = 3'd1; m_data = {48'h0, p_wdata}; end
      else if (rdd) begin m_code = 3'd2; m_data = {32'h0, p_rdata}; end
      else if (ov)  begin m_code = 3'd3; m_data = {48'h0, p_wdata}; end
      else          begin m_code = 3'd4; m_data = {32'h0, p_rdata}; end
    end
    if (wa) begin m_wlast = p_wdata; m_whp = 1'b1; end
    if (ra) begin m_rlast = p_rdata; m_rhp = 1'b1; end
    m_wcnt = sat(m_wcnt, wa);
    m_rcnt = sat(m_rcnt, ra);
    m_ocnt = sat(m_ocnt, ov);
    m_ecnt = sat(m_ecnt, any);
    m_wdup = wd; m_rdup = rdd; m_seq = sq; m_trig = any;
  endtask

  // One clock cycle of stimulus; leaves the bench 1 time unit after the edge.
  task automatic tick(input logic wen, input logic [WRW-1:0] wd, input logic fl,
                      input logic ren, input logic [RDW-1:0] rdv, input logic vl,
                      input logic clr, input logic rst);
    wr_en = wen; wr_data = wd; full = fl;
    rd_en = ren; rd_data = rdv; valid = vl;
    clear = clr; reset = rst;
    @(posedge clk);
    if (rst || clr) begin
      model_reset();
    end else begin
      model_apply();
      p_wen = wen; p_wdata = wd; p_full = fl;
      p_ren = ren; p_rdata = rdv; p_valid = vl;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, '0, 0, 0, '0, 0, 0, 0);
  endtask
  task automatic wr(input logic [WRW-1:0] d);
    tick(1, d, 0, 0, '0, 0, 0, 0);
  endtask
  task automatic rd(input logic [RDW-1:0] d);
    tick(0, '0, 0, 1, d, 1, 0, 0);
  endtask
  task automatic do_clear();
    tick(0, '0, 0, 0, '0, 0, 1, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [87:0] got;
    tick(1, 16'h1234, 0, 1, 32'h5, 1, 0, 1);
    tick(1, 16'h1234, 1, 1, 32'h5, 1, 0, 1);
    got = {wr_dup, rd_dup, seq_err, trig, triggered, first_code, first_data,
           wr_cnt, rd_cnt, err_cnt, ovf_cnt};
    checks++;
    if (got !== 88'h0) begin
      errors++;
      $display("FAIL reset_state got=%h expected=0", got);
    end
  endtask

  task automatic test_wr_dup();
    int pulses;
    do_clear();
    wr(16'h0001); wr(16'h0002); wr(16'h0002);
    idle(1);
    checks++;
    if (wr_dup !== 1'b1) begin
      errors++;
      $display("FAIL wr_dup_pulse got=%b expected=1", wr_dup);
    end
    pulses = 0;
    idle(1);
    if (wr_dup) pulses++;
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL wr_dup_single got=%0d extra pulses expected=0", pulses);
    end
    checks++;
    if ({wr_cnt, err_cnt, first_code, first_data, triggered} !==
        {4'd3, 4'd1, 3'd1, 64'h2, 1'b1}) begin
      errors++;
      $display("FAIL wr_dup_state got wr_cnt=%0d err=%0d code=%0d data=%h trg=%b expected 3 1 1 0002 1",
               wr_cnt, err_cnt, first_code, first_data, triggered);
    end
  endtask

  task automatic test_allones_first();
    int seen;
    seen = 0;
    do_clear();
    rd(32'hFFFF_FFFF); rd(32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      if (rd_dup || seq_err) seen++;
    end
    checks++;
    if (seen != 0 || triggered !== 1'b0 || rd_cnt !== 4'd2) begin
      errors++;
      $display("FAIL allones_first got pulses=%0d trg=%b rd_cnt=%0d expected 0 0 2",
               seen, triggered, rd_cnt);
    end
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < 5; i++) tick(1, 16'h00A0 + 16'(i), 1, 0, '0, 0, 0, 0);
    idle(2);
    checks++;
    if ({ovf_cnt, wr_cnt, err_cnt, first_code, first_data, triggered} !==
        {4'd5, 4'd0, 4'd5, 3'd3, 64'h00A0, 1'b1}) begin
      errors++;
      $display("FAIL overflow got ovf=%0d wr=%0d err=%0d code=%0d data=%h trg=%b expected 5 0 5 3 00a0 1",
               ovf_cnt, wr_cnt, err_cnt, first_code, first_data, triggered);
    end
  endtask

  task automatic test_saturation();
    int seen;
    seen = 0;
    do_clear();
    for (int i = 1; i <= 20; i++) begin
      rd(32'(i));
      if (seq_err || rd_dup) seen++;
    end
    idle(2);
    if (seq_err || rd_dup) seen++;
    checks++;
    if (rd_cnt !== 4'd15 || seen != 0 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL rd_cnt_saturate got cnt=%0d pulses=%0d trg=%b expected 15 0 0",
               rd_cnt, seen, triggered);
    end
  endtask

  task automatic test_seq_gap();
    logic exp_pulse;
`ifdef MON_SEQ_CHECK_EN
    exp_pulse = 1'b1;
`else
    exp_pulse = 1'b0;
`endif
    do_clear();
    rd(32'd5); rd(32'd7);
    idle(1);
    checks++;
    if (seq_err !== exp_pulse) begin
      errors++;
      $display("FAIL seq_gap_pulse got=%b expected=%b", seq_err, exp_pulse);
    end
    idle(1);
    checks++;
    if (exp_pulse) begin
      if ({triggered, first_code, first_data} !== {1'b1, 3'd4, 64'd7}) begin
        errors++;
        $display("FAIL seq_gap_capture got trg=%b code=%0d data=%h expected 1 4 7",
                 triggered, first_code, first_data);
      end
    end else if (triggered !== 1'b0) begin
      errors++;
      $display("FAIL seq_gap_capture got trg=%b expected 0", triggered);
    end
  endtask

  task automatic test_clear_same_cycle();
    int seen;
    seen = 0;
    do_clear();
    wr(16'h0009); wr(16'h0009);
    do_clear();              // duplicate is in S2 this cycle
    if (wr_dup) seen++;
    idle(1);
    if (wr_dup) seen++;
    checks++;
    if (seen != 0 || {wr_cnt, rd_cnt, err_cnt, ovf_cnt} !== 16'h0 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL clear_drop got pulses=%0d cnts=%h trg=%b expected 0 0 0",
               seen, {wr_cnt, rd_cnt, err_cnt, ovf_cnt}, triggered);
    end
    wr(16'h0009);
    idle(2);
    if (wr_dup) seen++;
    checks++;
    if (seen != 0 || wr_cnt !== 4'd1 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL clear_first_write got pulses=%0d wr_cnt=%0d trg=%b expected 0 1 0",
               seen, wr_cnt, triggered);
    end
  endtask

  task automatic test_random();
    logic [87:0]    got, exp;
    logic [RDW-1:0] last_rd;
    logic [RDW-1:0] rdv;
    logic           wen, fl, ren, vl, clr, rst;
    int             sel;
    last_rd = '0;
    do_clear();
    for (int i = 0; i < 1500; i++) begin
      wen = 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 3) == 0);
      ren = 1'($urandom_range(0, 1));
      vl  = ($urandom_range(0, 4) != 0);
      sel = $urandom_range(0, 5);
      if (sel < 4)       rdv = last_rd + 32'd1;
      else if (sel == 4) rdv = last_rd;
      else               rdv = $urandom;
      clr = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 299) == 0);
      if (ren && vl) last_rd = rdv;
      tick(wen, 16'($urandom_range(0, 3)), fl, ren, rdv, vl, clr, rst);
      got = {wr_dup, rd_dup, seq_err, trig, triggered, first_code, first_data,
             wr_cnt, rd_cnt, err_cnt, ovf_cnt};
      exp = {m_wdup, m_rdup, m_seq, m_trig, m_trigd, m_code, m_data,
             m_wcnt, m_rcnt, m_ecnt, m_ocnt};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_cycle_%0d got=%h expected=%h", i, got, exp);
      end
    end
  endtask

  initial begin
    model_reset();
    reset = 1'b1; clear = 1'b0;
    wr_en = 1'b0; wr_data = '0; full = 1'b0;
    rd_en = 1'b0; rd_data = '0; valid = 1'b0;
    #1;
    test_reset();
    test_wr_dup();
    test_allones_first();
    test_overflow();
    test_saturation();
    test_seq_gap();
    test_clear_same_cycle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
